// File: rtl/life_gen_controller_if.sv
// ---------------------------------------------------------------------------
// life_gen_controller_if
// Groups the control, seed and datapath signals around the Game of Life
// generation sequencer.
//   master : drives seed/load/run/step and the datapath result grid_evolve,
//            observes grid and status.
//   slave  : the sequencer itself.
// Grid bit 8*r+c is row r, column c.
// ---------------------------------------------------------------------------
interface life_gen_controller_if #(
    parameter int unsigned GEN_W = 16
);
    logic [63:0]      seed;
    logic             load;
    logic             run;
    logic             step;
    logic [63:0]      grid_evolve;
    logic [63:0]      grid;
    logic [GEN_W-1:0] gen_count;
    logic             gen_valid;
    logic             running;
    logic             stable;
    logic             extinct;

    modport master (
        output seed, load, run, step, grid_evolve,
        input  grid, gen_count, gen_valid, running, stable, extinct
    );

    modport slave (
        input  seed, load, run, step, grid_evolve,
        output grid, gen_count, gen_valid, running, stable, extinct
    );
endinterface

// File: rtl/life_gen_controller.sv
// ---------------------------------------------------------------------------
// life_gen_controller
// Generation sequencer for an 8x8 Game of Life engine. Holds the grid
// register feeding the external combinational evolution datapath and commits
// its result on a single step (IDLE) or every TICK_DIV cycles (RUN). Halts on
// still-life (stable) or an all-zero grid (extinct); only load or reset
// leave HALT.
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-high reset
//   bus    : slave side of life_gen_controller_if
//            in : seed, load, run, step, grid_evolve
//            out: grid, gen_count, gen_valid, running, stable, extinct
// ---------------------------------------------------------------------------
module life_gen_controller #(
    parameter int unsigned TICK_DIV = 4,
    parameter int unsigned GEN_W    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    life_gen_controller_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam logic [23:0] TICK_LAST = 24'(TICK_DIV - 1);

    state_t           r_state;
    logic [23:0]      r_tick_cnt;
    logic [63:0]      r_grid;
    logic [GEN_W-1:0] r_gen_count;
    logic             r_gen_valid;
    logic             r_running;
    logic             r_stable;
    logic             r_extinct;

    logic             w_commit;
    logic             w_same;
    logic             w_cnt_max;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        w_commit  = 1'b0;
        w_same    = (bus.grid_evolve == r_grid);
        w_cnt_max = &r_gen_count;
        if (r_state == S_IDLE)
            w_commit = bus.step;
        else if (r_state == S_RUN)
            // Dropping run on a due tick cancels that commit.
            w_commit = bus.run && (r_tick_cnt == TICK_LAST);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_tick_cnt  <= '0;
            r_grid      <= '0;
            r_gen_count <= '0;
            r_gen_valid <= 1'b0;
            r_running   <= 1'b0;
            r_stable    <= 1'b0;
            r_extinct   <= 1'b0;
        end else if (bus.load) begin
            r_state     <= S_IDLE;
            r_tick_cnt  <= '0;
            r_grid      <= bus.seed;
            r_gen_count <= '0;
            r_gen_valid <= 1'b0;
            r_running   <= 1'b0;
            r_stable    <= 1'b0;
            r_extinct   <= 1'b0;
        end else begin
            r_gen_valid <= 1'b0;

            // run/step transitions; a halting commit below overrides them.
            case (r_state)
                S_IDLE: begin
                    if (bus.run) begin
                        r_state    <= S_RUN;
                        r_running  <= 1'b1;
                        r_tick_cnt <= '0;
                    end
                end
                S_RUN: begin
                    if (!bus.run) begin
                        r_state    <= S_IDLE;
                        r_running  <= 1'b0;
                        r_tick_cnt <= '0;
                    end else if (r_tick_cnt == TICK_LAST) begin
                        r_tick_cnt <= '0;
                    end else begin
                        r_tick_cnt <= r_tick_cnt + 24'd1;
                    end
                end
                default: ;  // HALT: everything frozen
            endcase

            // NOTE: when two non-blocking assignments hit the same register in
            // one block, the later one wins; the halt here overrides the
            // IDLE->RUN move made above.
            if (w_commit) begin
                if (w_same) begin
                    // Nothing changes: still-life, or an already empty grid.
                    r_stable  <= (r_grid != 64'd0);
                    r_extinct <= (r_grid == 64'd0);
                    r_state   <= S_HALT;
                    r_running <= 1'b0;
                end else begin
                    r_grid      <= bus.grid_evolve;
                    r_gen_valid <= 1'b1;
                    if (!w_cnt_max)
                        r_gen_count <= r_gen_count + GEN_W'(1);
                    if (bus.grid_evolve == 64'd0) begin
                        r_extinct <= 1'b1;
                        r_state   <= S_HALT;
                        r_running <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.grid      = r_grid;
    assign bus.gen_count = r_gen_count;
    assign bus.gen_valid = r_gen_valid;
    assign bus.running   = r_running;
    assign bus.stable    = r_stable;
    assign bus.extinct   = r_extinct;

endmodule

// File: tb/tb_life_gen_controller.sv
// ---------------------------------------------------------------------------
// tb_life_gen_controller
// Two sequencers share one stimulus stream: dut_a (TICK_DIV=4, GEN_W=16) and
// dut_b (TICK_DIV=1, GEN_W=2, so its counter saturates quickly). The Life
// datapath and a generation-level reference model live in the bench; a
// negedge process compares both DUTs against the model every cycle, and
// directed literals pin the model to known patterns.
// ---------------------------------------------------------------------------
module tb_life_gen_controller;

    localparam int TD_A = 4;
    localparam int TD_B = 1;
    localparam int GW_A = 16;
    localparam int GW_B = 2;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    localparam logic [63:0] BLINK_H = 64'h0000_0000_0000_0E00;
    localparam logic [63:0] BLINK_V = 64'h0000_0000_0004_0404;
    localparam logic [63:0] BLOCK   = 64'h0000_0000_0006_0600;
    localparam logic [63:0] SINGLE  = 64'h0000_0000_0000_0200;
    localparam logic [63:0] BLINK_2 = 64'h0000_0000_0070_0000;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    life_gen_controller_if #(.GEN_W(GW_A)) if_a ();
    life_gen_controller_if #(.GEN_W(GW_B)) if_b ();

    life_gen_controller #(.TICK_DIV(TD_A), .GEN_W(GW_A)) dut_a (
        .clk(clk), .reset(reset), .bus(if_a.slave));
    life_gen_controller #(.TICK_DIV(TD_B), .GEN_W(GW_B)) dut_b (
        .clk(clk), .reset(reset), .bus(if_b.slave));

    assign if_b.seed = if_a.seed;
    assign if_b.load = if_a.load;
    assign if_b.run  = if_a.run;
    assign if_b.step = if_a.step;

    // Conway's rules on a bounded 8x8 board (cells outside are dead).
    function automatic logic [63:0] life_next(input logic [63:0] g);
        logic [63:0] nx;
        nx = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                int n;
                n = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 8 &&
                            c + dc >= 0 && c + dc < 8)
                            n += int'(g[8 * (r + dr) + (c + dc)]);
                nx[8 * r + c] = (n == 3) || (g[8 * r + c] && n == 2);
            end
        end
        return nx;
    endfunction

    always_comb if_a.grid_evolve = life_next(if_a.grid);
    always_comb if_b.grid_evolve = life_next(if_b.grid);

    typedef struct {
        logic [63:0] grid;
        int          cnt;
        int          tick;
        int          state;
        bit          valid;
        bit          stable;
        bit          extinct;
    } mdl_t;

    mdl_t ma = '{grid: '0, cnt: 0, tick: 0, state: M_IDLE, valid: 0, stable: 0, extinct: 0};
    mdl_t mb = '{grid: '0, cnt: 0, tick: 0, state: M_IDLE, valid: 0, stable: 0, extinct: 0};

    // One generation-level step of the sequencer as the rules describe it.
    function automatic mdl_t mdl_next(input mdl_t m, input bit ld, input bit rn,
                                      input bit st, input logic [63:0] sd,
                                      input int td, input int cmax);
        bit          commit;
        logic [63:0] nx;
        commit  = 1'b0;
        m.valid = 1'b0;
        if (ld) begin
            m.grid = sd; m.cnt = 0; m.tick = 0; m.state = M_IDLE;
            m.stable = 1'b0; m.extinct = 1'b0;
            return m;
        end
        if (m.state == M_IDLE) begin
            commit = st;
            if (rn) begin m.state = M_RUN; m.tick = 0; end
        end else if (m.state == M_RUN) begin
            if (!rn) begin
                m.state = M_IDLE; m.tick = 0;
            end else begin
                commit = (m.tick == td - 1);
                m.tick = (m.tick + 1) % td;
            end
        end
        if (commit) begin
            nx = life_next(m.grid);
            if (nx == m.grid) begin
                if (m.grid != 0) m.stable = 1'b1;
                else             m.extinct = 1'b1;
                m.state = M_HALT;
            end else begin
                m.grid  = nx;
                m.valid = 1'b1;
                if (m.cnt < cmax) m.cnt++;
                if (nx == 0) begin m.extinct = 1'b1; m.state = M_HALT; end
            end
        end
        return m;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ma = '{grid: '0, cnt: 0, tick: 0, state: M_IDLE, valid: 0, stable: 0, extinct: 0};
            mb = ma;
        end else begin
            ma = mdl_next(ma, if_a.load, if_a.run, if_a.step, if_a.seed, TD_A, (1 << GW_A) - 1);
            mb = mdl_next(mb, if_a.load, if_a.run, if_a.step, if_a.seed, TD_B, (1 << GW_B) - 1);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            check("a.grid",    if_a.grid,               ma.grid);
            check("a.count",   64'(if_a.gen_count),     64'(ma.cnt));
            check("a.valid",   64'(if_a.gen_valid),     64'(ma.valid));
            check("a.running", 64'(if_a.running),       64'(ma.state == M_RUN));
            check("a.stable",  64'(if_a.stable),        64'(ma.stable));
            check("a.extinct", 64'(if_a.extinct),       64'(ma.extinct));
            check("b.grid",    if_b.grid,               mb.grid);
            check("b.count",   64'(if_b.gen_count),     64'(mb.cnt));
            check("b.valid",   64'(if_b.gen_valid),     64'(mb.valid));
            check("b.running", 64'(if_b.running),       64'(mb.state == M_RUN));
            check("b.stable",  64'(if_b.stable),        64'(mb.stable));
            check("b.extinct", 64'(if_b.extinct),       64'(mb.extinct));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_seed(input logic [63:0] s);
        if_a.seed = s; if_a.load = 1'b1; if_a.run = 1'b0; if_a.step = 1'b0;
        cyc(1);
        if_a.load = 1'b0;
    endtask

    task automatic pulse_step();
        if_a.step = 1'b1;
        cyc(1);
        if_a.step = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        if_a.seed = '0; if_a.load = 1'b0; if_a.run = 1'b0; if_a.step = 1'b0;
        cyc(2);
        check("rst.grid",  if_a.grid, 64'd0);
        check("rst.count", 64'(if_a.gen_count), 64'd0);
        check("rst.flags", 64'({if_a.gen_valid, if_a.running, if_a.stable, if_a.extinct}), 64'd0);
        reset = 1'b0;

        // Single step on a blinker.
        load_seed(BLINK_H);
        check("bl.load", if_a.grid, BLINK_H);
        pulse_step();
        check("bl.s1.grid",  if_a.grid, BLINK_V);
        check("bl.s1.count", 64'(if_a.gen_count), 64'd1);
        check("bl.s1.valid", 64'(if_a.gen_valid), 64'd1);
        cyc(1);
        check("bl.s1.pulse", 64'(if_a.gen_valid), 64'd0);
        pulse_step();
        check("bl.s2.grid",   if_a.grid, BLINK_H);
        check("bl.s2.count",  64'(if_a.gen_count), 64'd2);
        check("bl.s2.stable", 64'(if_a.stable), 64'd0);

        // Free run: commits 4, 8 and 12 cycles after entering RUN.
        load_seed(BLINK_H);
        if_a.run = 1'b1;
        cyc(1);
        check("run.enter", 64'(if_a.running), 64'd1);
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            check("run.valid", 64'(if_a.gen_valid), 64'(i % 4 == 3));
        end
        check("run.count",   64'(if_a.gen_count), 64'd3);
        check("run.grid",    if_a.grid, BLINK_V);
        check("run.running", 64'(if_a.running), 64'd1);

        // Load on a due tick wins over the commit.
        cyc(3);
        if_a.seed = BLINK_2; if_a.load = 1'b1;
        cyc(1);
        if_a.load = 1'b0; if_a.run = 1'b0;
        check("ldtick.grid",  if_a.grid, BLINK_2);
        check("ldtick.count", 64'(if_a.gen_count), 64'd0);
        check("ldtick.run",   64'(if_a.running), 64'd0);
        check("ldtick.valid", 64'(if_a.gen_valid), 64'd0);

        // Dropping run on a due tick: no commit.
        if_a.run = 1'b1;
        cyc(4);
        if_a.run = 1'b0;
        cyc(1);
        check("drop.grid",  if_a.grid, BLINK_2);
        check("drop.count", 64'(if_a.gen_count), 64'd0);
        check("drop.run",   64'(if_a.running), 64'd0);

        // Still life halts; later step/run do nothing.
        load_seed(BLOCK);
        pulse_step();
        check("blk.stable", 64'(if_a.stable), 64'd1);
        check("blk.count",  64'(if_a.gen_count), 64'd0);
        check("blk.valid",  64'(if_a.gen_valid), 64'd0);
        check("blk.grid",   if_a.grid, BLOCK);
        if_a.run = 1'b1; if_a.step = 1'b1;
        cyc(6);
        if_a.run = 1'b0; if_a.step = 1'b0;
        check("blk.frozen", 64'({if_a.running, if_a.stable}), 64'b01);
        check("blk.grid2",  if_a.grid, BLOCK);

        // Single cell dies; empty grid stays extinct.
        load_seed(SINGLE);
        pulse_step();
        check("one.grid",    if_a.grid, 64'd0);
        check("one.count",   64'(if_a.gen_count), 64'd1);
        check("one.valid",   64'(if_a.gen_valid), 64'd1);
        check("one.extinct", 64'(if_a.extinct), 64'd1);
        load_seed(64'd0);
        pulse_step();
        check("zero.extinct", 64'(if_a.extinct), 64'd1);
        check("zero.count",   64'(if_a.gen_count), 64'd0);
        check("zero.valid",   64'(if_a.gen_valid), 64'd0);

        // TICK_DIV=1, 2-bit counter: saturates at all-ones.
        load_seed(BLINK_H);
        if_a.run = 1'b1;
        cyc(7);
        check("sat.count", 64'(if_b.gen_count), 64'd3);
        check("sat.grid",  if_b.grid, BLINK_H);
        check("sat.valid", 64'(if_b.gen_valid), 64'd1);

        // Async reset between edges clears everything at once.
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst.grid",  if_a.grid, 64'd0);
        check("arst.count", 64'(if_a.gen_count), 64'd0);
        check("arst.flags", 64'({if_a.gen_valid, if_a.running, if_a.stable, if_a.extinct}), 64'd0);
        check("arst.b",     if_b.grid, 64'd0);
        if_a.run = 1'b0;
        cyc(1);
        reset = 1'b0;

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(15) == 0) begin
                if_a.seed = {$urandom, $urandom} & {$urandom, $urandom};
                if_a.load = 1'b1;
            end else begin
                if_a.load = 1'b0;
            end
            if ($urandom_range(7) == 0) if_a.run = ~if_a.run;
            if_a.step = ($urandom_range(2) == 0);
            cyc(1);
        end
        if_a.load = 1'b0; if_a.run = 1'b0; if_a.step = 1'b0;
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
